dmem_doubleword_responder: RTL and testbench
============================================

# dmem_doubleword_responder

Memory-side responder for the multicycle RISC-V core's data-memory requests. It accepts one load or store per handshake from the control FSM and serialises 1/2/4/8-byte accesses into single-byte transfers on an internal byte-wide array. It reports completion with a one-cycle `done` pulse and returns load data zero-extended to 64 bits; sign extension stays in the datapath extender.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of the internal array; depth = 2**ADDR_W bytes. Must be ≥3.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req`  in  1  request strobe; sampled only while `busy`=0.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `size`  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword; beats = 1<<size.
- `addr`  in  64  byte address; only `addr[ADDR_W-1:0]` used, upper bits ignored (aliasing).
- `wdata`  in  64  store data; byte i = `wdata[8i+7:8i]`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misalignment flag; valid only while `done`=1, otherwise 0.
- `rdata`  out  64  load result; stable from `done` until the next accepted request.

## Operation
- States: IDLE, XFER, RESP.
- IDLE: `busy`=0, `done`=0. On an edge with `req`=1, latch `we`, `size`, `addr[ADDR_W-1:0]` as base, and `wdata`.
  - Aligned request: clear beat counter, clear the `rdata` accumulator when `we`=0, go to XFER.
  - Misaligned request: go straight to RESP with `err`=1. No array access; `rdata` unchanged. Misaligned means the low `size` bits of the address are nonzero.
- XFER: one beat per edge, beat i = counter value.
  - Store: writes byte i to `mem[base+i]`.
  - Load: captures the asynchronously read `mem[base+i]` into `rdata[8i+7:8i]`.
  - After beat beats-1 the FSM goes to RESP.
  - Upper `rdata` bytes beyond the access size are 0.
- RESP: `done`=1 and `busy`=1 for exactly one cycle; `err` reflects the latched result. Next edge returns to IDLE.
- `req` while `busy`=1 is ignored; there is no queue. The initiator re-presents the request after `done`.
- `req` held high across the RESP→IDLE edge is not accepted on that edge. It is accepted on the following edge, when the FSM is in IDLE.
- Address arithmetic is modulo 2**ADDR_W. Aligned accesses never straddle the array end.
- Array contents are not affected by reset and power up undefined.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counter 0, `busy`=0, `done`=0, `err`=0, `rdata`=0, latched request fields 0.
- Reset mid-XFER aborts immediately: no `done`, and store bytes already written remain written.
- Aligned access accepted at edge k: beats at edges k+1 … k+beats, `done` high between edges k+beats and k+beats+1, IDLE after edge k+beats+1. Latency: doubleword 9 cycles to `done`, byte 2 cycles.
- Misaligned request accepted at edge k: `done`=`err`=1 between edges k and k+1.
- Store data is visible to a load accepted on or after the RESP→IDLE edge.
- Back-to-back throughput for a doubleword: one access per 10 cycles (accept edge, 8 beats, RESP).

## Test plan
- Reset/idle: hold `reset`=0, pulse `req` → `busy`=0, `done`=0, `err`=0, `rdata`=0. Release reset → IDLE, with no activity until `req`.
- Doubleword round trip: store `wdata`=64'h0123_4567_89AB_CDEF at addr 8, then load addr 8 → store `done` 9 cycles after accept. Load `rdata`=64'h0123_4567_89AB_CDEF, `err`=0.
- Sub-word: store byte 8'hEF at addr 3, then load word addr 0 after prior doubleword 64'h1122_3344_5566_7788 at addr 0 → `rdata`=64'h0000_0000_EF66_7788. Load byte addr 3 → 64'h0000_0000_0000_00EF, `done` 2 cycles after accept.
- Misaligned: load size=3 addr 4, and store size=1 addr 1 → each gives `done`=`err`=1 one cycle after accept. Array unchanged (verified by an aligned reload). `rdata` keeps its previous value.
- Busy/aliasing: assert a second `req` (store addr 16) during XFER → ignored, array byte 16 unchanged. With ADDR_W=8, load addr 64'h100 returns the same data as addr 0.
- Reset mid-store: doubleword store of 64'hFFFF_FFFF_FFFF_FFFF to addr 0 (previously 0). Assert reset after beat 2 → `done` never pulses. Reload returns 64'h0000_0000_00FF_FFFF.

Source files
------------

// File: rtl/dmem_doubleword_responder.sv
// Data-memory responder: serialises 1/2/4/8-byte loads and stores into byte beats
// on an internal byte array, then reports completion with a one-cycle done pulse.
module dmem_doubleword_responder #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [63:0]       rdata_q, rdata_d;

  logic [7:0]        mem_q [0:(1<<ADDR_W)-1];

  logic              misalign_s;
  logic [2:0]        last_beat_s;
  logic [ADDR_W-1:0] beat_addr_s;
  logic [7:0]        rd_byte_s;
  logic [7:0]        wr_byte_s;
  logic              mem_we_s;
  logic              unused_addr_s;

  // Upper address bits alias onto the array and are deliberately ignored.
  assign unused_addr_s = ^addr[63:ADDR_W];

  assign beat_addr_s = base_q + ADDR_W'(cnt_q);
  assign rd_byte_s   = mem_q[beat_addr_s];
  assign wr_byte_s   = wdata_q[{cnt_q, 3'b000} +: 8];

  // Decode alignment of the incoming request and the final beat of the latched one.
  always_comb begin
    misalign_s  = 1'b0;
    last_beat_s = 3'd0;
    case (size)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = addr[0];
      2'd2:    misalign_s = |addr[1:0];
      2'd3:    misalign_s = |addr[2:0];
      default: misalign_s = 1'b0;
    endcase
    case (size_q)
      2'd0:    last_beat_s = 3'd0;
      2'd1:    last_beat_s = 3'd1;
      2'd2:    last_beat_s = 3'd3;
      2'd3:    last_beat_s = 3'd7;
      default: last_beat_s = 3'd0;
    endcase
  end

  // Next-state, beat sequencing and load-data accumulation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          base_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          if (misalign_s) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = 3'd0;
            state_d = XFER;
            if (!we) begin
              rdata_d = 64'd0;
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (we_q) begin
          mem_we_s = 1'b1;
        end else begin
          rdata_d[{cnt_q, 3'b000} +: 8] = rd_byte_s;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == last_beat_s) begin
          state_d = RESP;
        end else begin
          state_d = XFER;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      base_q  <= '0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte array: no reset, contents survive reset and power up undefined.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[beat_addr_s] <= wr_byte_s;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == RESP);
  assign err   = (state_q == RESP) & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_doubleword_responder.sv
// Directed self-checking bench for dmem_doubleword_responder.
module tb_dmem_doubleword_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;

  int errors;
  int checks;

  dmem_doubleword_responder #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, count edges after the accept edge until done, return outputs.
  task automatic issue(input logic w, input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] d, output int lat, output logic e,
                       output logic [63:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e  = err;
    rd = rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; addr = 64'd0; wdata = 64'd0;
    repeat (2) @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd3;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_roundtrip();
    int lat; logic e; logic [63:0] rd;
    issue(1'b1, 2'd3, 64'd8, 64'h0123_4567_89AB_CDEF, lat, e, rd);
    checks++; if (lat !== 8) begin errors++; $display("FAIL dw_store_lat got=%0d exp=8", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL dw_store_err got=%b exp=0", e); end
    issue(1'b0, 2'd3, 64'd8, 64'd0, lat, e, rd);
    checks++; if (lat !== 8) begin errors++; $display("FAIL dw_load_lat got=%0d exp=8", lat); end
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL dw_load_data got=%h exp=0123456789abcdef", rd);
    end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL dw_load_err got=%b exp=0", e); end
  endtask

  task automatic test_subword();
    int lat; logic e; logic [63:0] rd;
    issue(1'b1, 2'd3, 64'd0, 64'h1122_3344_5566_7788, lat, e, rd);
    issue(1'b1, 2'd0, 64'd3, 64'h0000_0000_0000_00EF, lat, e, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL byte_store_lat got=%0d exp=1", lat); end
    issue(1'b0, 2'd2, 64'd0, 64'd0, lat, e, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL word_load_lat got=%0d exp=4", lat); end
    checks++; if (rd !== 64'h0000_0000_EF66_7788) begin
      errors++; $display("FAIL word_load_data got=%h exp=00000000ef667788", rd);
    end
    issue(1'b0, 2'd0, 64'd3, 64'd0, lat, e, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL byte_load_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 64'h0000_0000_0000_00EF) begin
      errors++; $display("FAIL byte_load_data got=%h exp=00000000000000ef", rd);
    end
    issue(1'b0, 2'd1, 64'd6, 64'd0, lat, e, rd);
    checks++; if (rd !== 64'h0000_0000_0000_1122 || lat !== 2) begin
      errors++; $display("FAIL half_load got=%h lat=%0d exp=1122 lat=2", rd, lat);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic e; logic [63:0] rd;
    issue(1'b0, 2'd3, 64'd4, 64'd0, lat, e, rd);
    checks++; if (lat !== 0 || e !== 1'b1) begin
      errors++; $display("FAIL mis_load lat=%0d err=%b exp=0/1", lat, e);
    end
    checks++; if (rd !== 64'h0000_0000_0000_1122) begin
      errors++; $display("FAIL mis_load_rdata got=%h exp=1122", rd);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_outside_done got=%b exp=0", err); end
    issue(1'b1, 2'd1, 64'd1, 64'h0000_0000_0000_FFFF, lat, e, rd);
    checks++; if (lat !== 0 || e !== 1'b1) begin
      errors++; $display("FAIL mis_store lat=%0d err=%b exp=0/1", lat, e);
    end
    issue(1'b0, 2'd3, 64'd0, 64'd0, lat, e, rd);
    checks++; if (rd !== 64'h1122_3344_EF66_7788 || e !== 1'b0) begin
      errors++; $display("FAIL mis_reload got=%h err=%b exp=11223344ef667788/0", rd, e);
    end
  endtask

  task automatic test_busy_alias();
    int lat; logic e; logic [63:0] rd;
    issue(1'b1, 2'd3, 64'd16, 64'hA5A5_A5A5_A5A5_A5A5, lat, e, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd3; addr = 64'd0; wdata = 64'd0;
    @(posedge clk); #1;
    we = 1'b1; addr = 64'd16; wdata = 64'd0; size = 2'd0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    checks++; if (lat !== 8 || rdata !== 64'h1122_3344_EF66_7788) begin
      errors++; $display("FAIL busy_load lat=%0d got=%h exp=8/11223344ef667788", lat, rdata);
    end
    @(posedge clk); #1;
    issue(1'b0, 2'd0, 64'd16, 64'd0, lat, e, rd);
    checks++; if (rd !== 64'h0000_0000_0000_00A5) begin
      errors++; $display("FAIL busy_ignored got=%h exp=a5", rd);
    end
    issue(1'b0, 2'd3, 64'h100, 64'd0, lat, e, rd);
    checks++; if (rd !== 64'h1122_3344_EF66_7788) begin
      errors++; $display("FAIL alias_load got=%h exp=11223344ef667788", rd);
    end
  endtask

  task automatic test_reset_mid_store();
    int lat; logic e; logic [63:0] rd; int saw_done;
    issue(1'b1, 2'd3, 64'd0, 64'd0, lat, e, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd3; addr = 64'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done++;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL midreset_done got=%0d exp=0", saw_done); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL midreset_rdata got=%h exp=0", rdata); end
    @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 2'd3, 64'd0, 64'd0, lat, e, rd);
    checks++; if (rd !== 64'h0000_0000_00FF_FFFF) begin
      errors++; $display("FAIL midreset_reload got=%h exp=0000000000ffffff", rd);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_roundtrip();
    test_subword();
    test_misaligned();
    test_busy_alias();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
